// File: rtl/reg_fault_monitor.sv
// rtl/reg_fault_monitor.sv - sticky register-upset monitor with baseline snapshot and event counter
// Optional FAULT_TIMESTAMP_EN adds first_ts, the ARMED-cycle index of the first fault event.
module reg_fault_monitor #(
    parameter int N_REGS = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              stop,
    input  logic [N_REGS-1:0] regs_in,
    output logic              busy,
    output logic [N_REGS-1:0] fault_map,
    output logic [CNT_W-1:0]  fault_count,
    output logic              fault_valid,
    input  logic              fault_ready
`ifdef FAULT_TIMESTAMP_EN
    ,
    output logic [31:0]       first_ts
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNAP   = 2'd1,
        ARMED  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_REGS-1:0] base_q, base_d;
    logic [N_REGS-1:0] map_q, map_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              prev_nz_q, prev_nz_d;
    logic [N_REGS-1:0] diff;
    logic              diff_nz;
    logic              fault_event;

`ifdef FAULT_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] first_ts_q, first_ts_d;
`endif

    assign diff        = regs_in ^ base_q;
    assign diff_nz     = |diff;
    assign fault_event = diff_nz && !prev_nz_q;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        map_d     = map_q;
        cnt_d     = cnt_q;
        prev_nz_d = prev_nz_q;
`ifdef FAULT_TIMESTAMP_EN
        ts_d       = ts_q;
        first_ts_d = first_ts_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm) state_d = SNAP;
            end
            SNAP: begin
                base_d    = regs_in;
                map_d     = '0;
                cnt_d     = '0;
                prev_nz_d = 1'b0;
`ifdef FAULT_TIMESTAMP_EN
                ts_d       = '0;
                first_ts_d = '1;
`endif
                state_d   = ARMED;
            end
            ARMED: begin
                map_d     = map_q | diff;
                prev_nz_d = diff_nz;
                if (fault_event && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
`ifdef FAULT_TIMESTAMP_EN
                if (ts_q != 32'hFFFF_FFFF) ts_d = ts_q + 32'd1;
                // Count is still zero only before the first event of the window.
                if (fault_event && (cnt_q == '0)) first_ts_d = ts_q;
`endif
                if (stop) state_d = REPORT;
            end
            REPORT: begin
                if (fault_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            map_q     <= '0;
            cnt_q     <= '0;
            prev_nz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            map_q     <= map_d;
            cnt_q     <= cnt_d;
            prev_nz_q <= prev_nz_d;
        end
    end

`ifdef FAULT_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            first_ts_q <= '0;
        end else begin
            ts_q       <= ts_d;
            first_ts_q <= first_ts_d;
        end
    end

    assign first_ts = first_ts_q;
`endif

    assign busy        = (state_q == SNAP) || (state_q == ARMED);
    assign fault_valid = (state_q == REPORT);
    assign fault_map   = map_q;
    assign fault_count = cnt_q;

endmodule

// File: tb/tb_reg_fault_monitor.sv
// tb/tb_reg_fault_monitor.sv - scoreboard bench for reg_fault_monitor (CNT_W=16 and CNT_W=2 in parallel)
module tb_reg_fault_monitor;

    logic       clk = 1'b0;
    logic       rst, arm, stop, fault_ready;
    logic [7:0] regs_in;

    logic        busy1, valid1, busy2, valid2;
    logic [7:0]  map1, map2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    typedef struct packed {
        logic [7:0]  map;
        logic [15:0] cnt;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic pv1 = 1'b0;
    logic pv2 = 1'b0;

    always #5 clk = ~clk;

    reg_fault_monitor #(.N_REGS(8), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .regs_in(regs_in),
        .busy(busy1), .fault_map(map1), .fault_count(cnt1),
        .fault_valid(valid1), .fault_ready(fault_ready)
    );

    reg_fault_monitor #(.N_REGS(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .regs_in(regs_in),
        .busy(busy2), .fault_map(map2), .fault_count(cnt2),
        .fault_valid(valid2), .fault_ready(fault_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: compare each new report against the oldest expected entry.
    always @(negedge clk) begin
        if (valid1 && !pv1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_report", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_fault_map", {24'd0, map1}, {24'd0, e.map});
                check("dut1_fault_count", {16'd0, cnt1}, {16'd0, e.cnt});
            end
        end
        pv1 = valid1;
        if (valid2 && !pv2) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_report", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("dut2_fault_map", {24'd0, map2}, {24'd0, e.map});
                check("dut2_fault_count", {30'd0, cnt2}, {16'd0, e.cnt});
            end
        end
        pv2 = valid2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_window(input logic [7:0] base);
        regs_in = base;
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
    endtask

    task automatic cyc(input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) begin
            regs_in = val;
            step();
        end
    endtask

    task automatic stop_window(input logic [7:0] val, input logic [7:0] emap,
                               input logic [15:0] ec1, input logic [15:0] ec2);
        exp_t e;
        e.map = emap;
        e.cnt = ec1;
        q1.push_back(e);
        e.cnt = ec2;
        q2.push_back(e);
        regs_in = val;
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic finish_report();
        int k;
        k = 0;
        fault_ready = 1'b1;
        while ((valid1 || valid2) && k < 5) begin
            step();
            k++;
        end
        check("report_drains", {30'd0, valid1, valid2}, 32'd0);
        fault_ready = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; stop = 1'b0; fault_ready = 1'b0; regs_in = 8'h00;
        step();
        step();
        rst = 1'b0;
        check("reset_busy", {31'd0, busy1}, 32'd0);
        check("reset_valid", {31'd0, valid1}, 32'd0);
        check("reset_map", {24'd0, map1}, 32'd0);
        check("reset_count", {16'd0, cnt1}, 32'd0);

        // stop and fault_ready in IDLE are ignored
        stop = 1'b1; fault_ready = 1'b1;
        step();
        step();
        stop = 1'b0; fault_ready = 1'b0;
        check("idle_ignore_busy", {31'd0, busy1}, 32'd0);
        check("idle_ignore_valid", {31'd0, valid1}, 32'd0);

        // No-fault window
        arm_window(8'hA5);
        check("armed_busy", {30'd0, busy1, busy2}, 32'd3);
        cyc(10, 8'hA5);
        stop_window(8'hA5, 8'h00, 16'd0, 16'd0);
        finish_report();

        // Single transient of three cycles
        arm_window(8'hA5);
        cyc(2, 8'hA5);
        cyc(3, 8'hA4);
        cyc(2, 8'hA5);
        stop_window(8'hA5, 8'h01, 16'd1, 16'd1);
        finish_report();

        // Two separated glitches on bits 7 and 3
        arm_window(8'hA5);
        cyc(1, 8'hA5);
        cyc(1, 8'h25);
        cyc(2, 8'hA5);
        cyc(1, 8'hAD);
        cyc(1, 8'hA5);
        stop_window(8'hA5, 8'h88, 16'd2, 16'd2);
        finish_report();

        // Diff present only in the stop cycle is still merged and counted
        arm_window(8'hA5);
        cyc(3, 8'hA5);
        stop_window(8'hE5, 8'h40, 16'd1, 16'd1);
        finish_report();

        // Saturation: five separated glitches, CNT_W=2 saturates at 3
        arm_window(8'hA5);
        for (int g = 0; g < 5; g++) begin
            cyc(1, 8'hA4);
            cyc(1, 8'hA5);
        end
        stop_window(8'hA5, 8'h01, 16'd5, 16'd3);
        finish_report();

        // arm+stop together in ARMED: stop wins; then hold the report
        arm_window(8'hA5);
        cyc(1, 8'hA5);
        cyc(1, 8'hA4);
        arm = 1'b1;
        stop_window(8'hA4, 8'h01, 16'd1, 16'd1);
        for (int i = 0; i < 4; i++) begin
            arm = 1'b1;
            check("hold_valid", {31'd0, valid1}, 32'd1);
            check("hold_busy", {31'd0, busy1}, 32'd0);
            check("hold_map", {24'd0, map1}, 32'h01);
            check("hold_count", {16'd0, cnt1}, 32'd1);
            step();
        end
        arm = 1'b0;
        fault_ready = 1'b1;
        step();
        fault_ready = 1'b0;
        check("ready_to_idle_valid", {31'd0, valid1}, 32'd0);
        check("ready_to_idle_busy", {31'd0, busy1}, 32'd0);
        check("idle_holds_map", {24'd0, map1}, 32'h01);
        check("idle_holds_count", {16'd0, cnt1}, 32'd1);
        step();
        check("arm_in_report_ignored", {31'd0, busy1}, 32'd0);

        // Reset mid-ARMED, with stop asserted alongside
        arm_window(8'hA5);
        cyc(1, 8'hA5);
        cyc(1, 8'hB5);
        check("pre_reset_map", {24'd0, map1}, 32'h10);
        check("pre_reset_count", {16'd0, cnt1}, 32'd1);
        rst = 1'b1; stop = 1'b1;
        step();
        rst = 1'b0; stop = 1'b0;
        check("post_reset_busy", {31'd0, busy1}, 32'd0);
        check("post_reset_valid", {31'd0, valid1}, 32'd0);
        check("post_reset_map", {24'd0, map1}, 32'd0);
        check("post_reset_count", {16'd0, cnt1}, 32'd0);
        check("post_reset_dut2", {22'd0, busy2, valid2, map2}, 32'd0);
        step();
        step();
        check("post_reset_stays_idle", {30'd0, busy1, valid1}, 32'd0);

        check("scoreboard_drained", q1.size() + q2.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
